// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-memory request/response channel plus the fetch-to-buffer packet type
typedef struct packed {
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] npc;
} if_ib_packet_t;

interface fetch_unit_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with squash/drain and buffer backpressure
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash_in,
  input  logic [31:0]         target_pc_in,
  input  logic                ib_full,
  fetch_unit_if.master        mem,
  output if_ib_packet_t       if_ib_packet,
  output logic [31:0]         fetch_count
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        req_valid;
  logic        outstanding;
  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = pc;
  // a request stays in flight past this edge, so its response must be dropped later
  assign outstanding = ((state == WAIT || state == DRAIN) && !mem.mem_resp_valid) ||
                       (state == REQ && mem.mem_req_ready);
  // fetch FSM; squash overrides everything, req_valid is kept registered alongside state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      req_valid    <= 1'b1;
      pc           <= RESET_PC;
      if_ib_packet <= '0;
      fetch_count  <= '0;
    end else if (squash_in) begin
      pc           <= target_pc_in;
      if_ib_packet <= '0;
      state        <= outstanding ? DRAIN : REQ;
      req_valid    <= !outstanding;
    end else begin
      case (state)
        REQ: if (mem.mem_req_ready) begin
          state     <= WAIT;
          req_valid <= 1'b0;
        end
        WAIT: if (mem.mem_resp_valid) begin
          if_ib_packet <= '{valid: 1'b1, inst: mem.mem_resp_data, pc: pc, npc: pc + 32'd4};
          state        <= HOLD;
        end
        HOLD: if (!ib_full) begin
          pc           <= pc + 32'd4;
          if_ib_packet <= '0;
          fetch_count  <= fetch_count + 32'd1;
          state        <= REQ;
          req_valid    <= 1'b1;
        end
        default: if (mem.mem_resp_valid) begin
          state     <= REQ;
          req_valid <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, backpressure, squash, PC wrap and async reset
module tb_fetch_unit;
  logic          clock = 1'b0;
  logic          reset;
  logic          squash_in;
  logic [31:0]   target_pc_in;
  logic          ib_full;
  logic          ready;
  logic          resp_valid;
  logic [31:0]   resp_data;
  if_ib_packet_t pkt0, pkt1;
  logic [31:0]   cnt0, cnt1;
  int            tests = 0;
  int            fails = 0;
  fetch_unit_if m0();
  fetch_unit_if m1();
  assign m0.mem_req_ready  = ready;
  assign m0.mem_resp_valid = resp_valid;
  assign m0.mem_resp_data  = resp_data;
  assign m1.mem_req_ready  = ready;
  assign m1.mem_resp_valid = resp_valid;
  assign m1.mem_resp_data  = resp_data;
  fetch_unit dut0 (
    .clock(clock), .reset(reset), .squash_in(squash_in), .target_pc_in(target_pc_in),
    .ib_full(ib_full), .mem(m0), .if_ib_packet(pkt0), .fetch_count(cnt0)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clock(clock), .reset(reset), .squash_in(squash_in), .target_pc_in(target_pc_in),
    .ib_full(ib_full), .mem(m1), .if_ib_packet(pkt1), .fetch_count(cnt1)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b1; squash_in = 1'b0; target_pc_in = '0; ib_full = 1'b0;
    ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    #2;
    chk("rst_req_valid", m0.mem_req_valid, 1);
    chk("rst_addr", m0.mem_req_addr, 0);
    chk("rst_pkt", pkt0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_addr_wrap", m1.mem_req_addr, 32'hFFFF_FFFC);
    #5;
    reset = 1'b0; ready = 1'b1;
    step();
    chk("wait_req_valid", m0.mem_req_valid, 0);
    ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h00A0_0093;
    step();
    resp_valid = 1'b0;
    chk("basic_pkt", pkt0, {1'b1, 32'h00A0_0093, 32'h0, 32'h4});
    chk("wrap_pkt", pkt1, {1'b1, 32'h00A0_0093, 32'hFFFF_FFFC, 32'h0});
    chk("hold_req_valid", m0.mem_req_valid, 0);
    step();
    chk("basic_pkt_gone", pkt0.valid, 0);
    chk("basic_cnt", cnt0, 1);
    chk("basic_next_req", m0.mem_req_valid, 1);
    chk("basic_next_addr", m0.mem_req_addr, 4);
    chk("wrap_next_addr", m1.mem_req_addr, 0);
    ready = 1'b1;
    step();
    ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h1234_5678;
    step();
    resp_valid = 1'b0; ib_full = 1'b1;
    chk("bp_pkt0", pkt0, {1'b1, 32'h1234_5678, 32'h4, 32'h8});
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_pkt_held", pkt0, {1'b1, 32'h1234_5678, 32'h4, 32'h8});
      chk("bp_cnt_held", cnt0, 1);
    end
    ib_full = 1'b0;
    step();
    chk("bp_cnt", cnt0, 2);
    chk("bp_pkt_gone", pkt0.valid, 0);
    chk("bp_next_addr", m0.mem_req_addr, 8);
    step();
    chk("bp_single_xfer", cnt0, 2);
    ready = 1'b1;
    step();
    ready = 1'b0; squash_in = 1'b1; target_pc_in = 32'h100;
    step();
    squash_in = 1'b0;
    chk("drain_req_valid", m0.mem_req_valid, 0);
    chk("drain_addr", m0.mem_req_addr, 32'h100);
    resp_valid = 1'b1; resp_data = 32'hDEAD_BEEF;
    step();
    resp_valid = 1'b0;
    chk("drain_dropped", pkt0.valid, 0);
    chk("drain_req_again", m0.mem_req_valid, 1);
    chk("drain_addr_after", m0.mem_req_addr, 32'h100);
    chk("drain_cnt", cnt0, 2);
    ready = 1'b1;
    step();
    ready = 1'b0; resp_valid = 1'b1; squash_in = 1'b1; target_pc_in = 32'h200;
    step();
    resp_valid = 1'b0; squash_in = 1'b0;
    chk("coinc_req_valid", m0.mem_req_valid, 1);
    chk("coinc_addr", m0.mem_req_addr, 32'h200);
    chk("coinc_pkt", pkt0.valid, 0);
    step();
    chk("coinc_still_req", m0.mem_req_valid, 1);
    ready = 1'b1;
    step();
    ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0013;
    step();
    resp_valid = 1'b0;
    chk("hold_sq_pkt", pkt0, {1'b1, 32'h0000_0013, 32'h200, 32'h204});
    squash_in = 1'b1; target_pc_in = 32'h300;
    step();
    squash_in = 1'b0;
    chk("hold_sq_cnt", cnt0, 2);
    chk("hold_sq_pkt_gone", pkt0.valid, 0);
    chk("hold_sq_addr", m0.mem_req_addr, 32'h300);
    chk("hold_sq_req", m0.mem_req_valid, 1);
    ready = 1'b1;
    step();
    ready = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0073;
    step();
    resp_valid = 1'b0; ib_full = 1'b1;
    chk("ar_pkt_valid", pkt0.valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pkt_cleared", pkt0, 0);
    chk("ar_cnt_cleared", cnt0, 0);
    chk("ar_req_valid", m0.mem_req_valid, 1);
    chk("ar_addr", m0.mem_req_addr, 0);
    reset = 1'b0; ib_full = 1'b0;
    step();
    chk("ar_after_req", m0.mem_req_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: squash_in  input  1  redirect; fetch restarts at target_pc_in.
REQ-005 Port: target_pc_in  input  32  redirect PC; sampled only when squash_in=1.
REQ-006 Port: ib_full  input  1  instruction buffer full; a packet transfers only while this is 0.
REQ-007 Port: mem_req_valid  output  1  fetch request valid.
REQ-008 Port: mem_req_addr  output  32  fetch address, always equal to the current PC.
REQ-009 Port: mem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 Port: mem_resp_valid  input  1  response data valid; memory returns responses in order, at most one outstanding.
REQ-011 Port: mem_resp_data  input  32  instruction word.
REQ-012 Port: if_ib_packet  output  IF_IB_PACKET  fields valid, inst[31:0], PC[31:0], NPC[31:0]; all fields driven from registers.
REQ-013 Port: fetch_count  output  32  number of packets transferred to the buffer.

Function
REQ-014 The FSM SHALL have four states: REQ, WAIT, HOLD and DRAIN.
REQ-015 REQ SHALL assert mem_req_valid=1 with mem_req_addr=pc; on mem_req_ready=1 it SHALL go to WAIT; otherwise it SHALL remain in REQ.
REQ-016 mem_req_valid SHALL be 0 in every state except REQ.
REQ-017 WAIT on mem_resp_valid=1 SHALL register the packet {valid=1, inst=mem_resp_data, PC=pc, NPC=pc+4} and go to HOLD; response-to-packet latency is 1 cycle.
REQ-018 HOLD SHALL present the packet with valid=1; in a cycle with ib_full=0 the transfer SHALL complete.
REQ-019 On transfer completion: pc<=pc+4, packet cleared to 0, fetch_count incremented, state<=REQ.
REQ-020 While ib_full=1 in HOLD, the packet SHALL remain valid and unchanged indefinitely.
REQ-021 if_ib_packet.valid SHALL be 1 only in HOLD.
REQ-022 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-023 fetch_count SHALL wrap modulo 2^32.
REQ-024 squash_in=1 SHALL take priority over every other event: pc<=target_pc_in, packet cleared, no transfer counted.
REQ-025 On squash_in, the next state SHALL be selected as follows:
  - DRAIN if a request is outstanding after this edge: state WAIT without mem_resp_valid, state DRAIN without mem_resp_valid, or state REQ with mem_req_ready=1.
  - REQ in all other cases.
REQ-026 A squash in HOLD with ib_full=0 SHALL NOT count a transfer.
REQ-027 DRAIN SHALL discard the response on mem_resp_valid=1 (no packet emitted) and go to REQ with the current pc.
REQ-028 A further squash in DRAIN SHALL update pc only.
REQ-029 mem_resp_valid SHALL be ignored in REQ and HOLD.

Reset
REQ-030 On reset assertion, regardless of clock: state=REQ, pc=RESET_PC, if_ib_packet=0, fetch_count=0.
REQ-031 On reset, mem_req_valid=1 and mem_req_addr=RESET_PC become visible immediately.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request with no discard tracking; the memory is reset by the same signal.

Verification
REQ-033 Scenario, basic fetch: reset, mem_req_ready=1, response 1 cycle later with data 32'h00A00093, ib_full=0 -> packet {1, 32'h00A00093, 0, 4} for exactly 1 cycle; fetch_count=1; next request addr 4.
REQ-034 Scenario, backpressure: ib_full=1 for 5 cycles during HOLD -> packet held stable 5 cycles; after ib_full falls, exactly one transfer and fetch_count increments by 1.
REQ-035 Scenario, squash in WAIT: squash_in with target 32'h100 while WAIT -> DRAIN; next response dropped (valid stays 0); following request addr 32'h100.
REQ-036 Scenario, squash coincident with response in WAIT: response dropped; state REQ next cycle, addr=target, no DRAIN.
REQ-037 Scenario, PC wrap and reset: RESET_PC=32'hFFFF_FFFC -> first packet NPC=0; next request addr 0.
REQ-038 Scenario, async reset: reset asserted mid-HOLD, between clock edges -> valid drops to 0 and fetch_count=0 before the next edge.
